// File: rtl/seg_scan_driver.sv
// seg_scan_driver: double-buffered 4-digit seven-segment scanner.
// Shows a, b, carry and sum on a shared active-low segment bus.
module seg_scan_driver #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] sum,
    input  logic       co,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frame,
    output logic       valid
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;
    logic [3:0]    pa_q, pb_q, ps_q, pa_d, pb_d, ps_d;
    logic          pc_q, pv_q, pc_d, pv_d;
    logic [3:0]    da_q, db_q, ds_q, da_d, db_d, ds_d;
    logic          dc_q, valid_q, seen_q, dc_d, valid_d, seen_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          frame_q, frame_d;
    logic          wrap, blank;
    logic [3:0]    val;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Next-state: slot timing, buffers, and the registered output image
    // of the slot position the counter currently holds.
    always_comb begin
        wrap  = (cnt_q == LAST);
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        dig_d = wrap ? dig_q + 2'd1 : dig_q;

        pa_d = load ? a   : pa_q;
        pb_d = load ? b   : pb_q;
        ps_d = load ? sum : ps_q;
        pc_d = load ? co  : pc_q;
        pv_d = pv_q | load;

        // Old pending values are copied here, so a load on the
        // boundary edge waits for the next boundary.
        da_d    = wrap ? pa_q : da_q;
        db_d    = wrap ? pb_q : db_q;
        ds_d    = wrap ? ps_q : ds_q;
        dc_d    = wrap ? pc_q : dc_q;
        valid_d = valid_q | (wrap & pv_q);
        seen_d  = seen_q | wrap;

        val = 4'h0;
        unique case (dig_q)
            2'd0: val = ds_q;
            2'd1: val = {3'b000, dc_q};
            2'd2: val = db_q;
            default: val = da_q;
        endcase

        blank = (int'(cnt_q) < BLANK_CYCLES);
        if (blank) begin
            an_d  = 4'hF;
            seg_d = 7'h7F;
        end else begin
            an_d  = ~(4'b0001 << dig_q);
            seg_d = valid_q ? hex7(val) : 7'h3F;
        end

        frame_d = (cnt_q == '0) && (dig_q == 2'd0) && seen_q;
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            dig_q   <= '0;
            pa_q    <= '0;
            pb_q    <= '0;
            ps_q    <= '0;
            pc_q    <= 1'b0;
            pv_q    <= 1'b0;
            da_q    <= '0;
            db_q    <= '0;
            ds_q    <= '0;
            dc_q    <= 1'b0;
            valid_q <= 1'b0;
            seen_q  <= 1'b0;
            seg_q   <= 7'h7F;
            an_q    <= 4'hF;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            pa_q    <= pa_d;
            pb_q    <= pb_d;
            ps_q    <= ps_d;
            pc_q    <= pc_d;
            pv_q    <= pv_d;
            da_q    <= da_d;
            db_q    <= db_d;
            ds_q    <= ds_d;
            dc_q    <= dc_d;
            valid_q <= valid_d;
            seen_q  <= seen_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign frame = frame_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed bench with a slot-level display model.
// Model works in edges-since-reset, slots and snapshots of loads.
module tb_seg_scan_driver;

    localparam int DIV = 8;
    localparam int BLK = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       load  = 1'b0;
    logic [3:0] a     = 4'h0;
    logic [3:0] b     = 4'h0;
    logic [3:0] sum   = 4'h0;
    logic       co    = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame;
    logic       valid;

    seg_scan_driver #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLK)) dut (
        .clock(clock), .reset(reset), .load(load),
        .a(a), .b(b), .sum(sum), .co(co),
        .seg(seg), .an(an), .frame(frame), .valid(valid)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int k = 0;

    logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                             7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                             7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)",
                     nm, act, exp, k);
        end
    endtask

    // Model state: pending load and the snapshot shown in the current slot
    logic [3:0] pa, pb, ps, sa, sb, ss, ia, ib, is, v;
    logic       pc, pv, sc, sv, ic, ld;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_val, e_frm;
    int         slot, pos, dg;

    always @(posedge clock) begin
        if (reset) begin
            k = 0;
            pa = 0; pb = 0; ps = 0; pc = 0; pv = 0;
            sa = 0; sb = 0; ss = 0; sc = 0; sv = 0;
        end else begin
            ld = load; ia = a; ib = b; is = sum; ic = co;
            k = k + 1;
            slot = (k - 1) / DIV;
            pos  = (k - 1) % DIV;
            dg   = slot % 4;
            e_an = 4'hF;
            e_seg = 7'h7F;
            if (pos >= BLK) begin
                e_an[dg] = 1'b0;
                case (dg)
                    0: v = ss;
                    1: v = {3'b000, sc};
                    2: v = sb;
                    default: v = sa;
                endcase
                e_seg = sv ? HEX[v] : 7'h3F;
            end
            if (k % DIV == 0) begin
                sa = pa; sb = pb; ss = ps; sc = pc;
                sv = sv | pv;
            end
            if (ld) begin
                pa = ia; pb = ib; ps = is; pc = ic; pv = 1'b1;
            end
            e_val = sv;
            e_frm = (k > 1) && ((k - 1) % (4 * DIV) == 0);
            #1;
            if (!reset) begin
                chk("an", an, e_an);
                chk("seg", seg, e_seg);
                chk("valid", valid, e_val);
                chk("frame", frame, e_frm);
            end
        end
    end

    task automatic wait_k(input int t);
        int g = 0;
        while (k < t && g < 1000) begin
            @(negedge clock);
            g++;
        end
        chk("wait_k", k, t);
    endtask

    task automatic do_load(input logic [3:0] va, input logic [3:0] vb,
                           input logic [3:0] vs, input logic vc);
        a = va; b = vb; sum = vs; co = vc; load = 1'b1;
        @(negedge clock);
        load = 1'b0;
    endtask

    int cnt0, nf, lastf;
    logic saw24, saw10;

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;

        cnt0 = 0;
        while (k < 64) begin
            @(negedge clock);
            if (an == 4'b1110) cnt0++;
            if (k == 3) begin
                chk("first_an", an, 4'b1110);
                chk("first_seg", seg, 7'h3F);
            end
        end
        chk("dig0_low_clocks", cnt0, 12);
        chk("noload_valid", valid, 1'b0);

        do_load(4'h5, 4'hA, 4'hF, 1'b1);
        wait_k(71);
        chk("valid_before", valid, 1'b0);
        wait_k(72);
        chk("valid_after", valid, 1'b1);
        wait_k(75);
        chk("d1_an", an, 4'b1101);
        chk("d1_seg", seg, 7'h79);
        wait_k(83);
        chk("d2_seg", seg, 7'h08);
        wait_k(91);
        chk("d3_seg", seg, 7'h12);
        wait_k(97);
        chk("frame_lit", frame, 1'b1);
        wait_k(99);
        chk("d0_seg", seg, 7'h0E);

        wait_k(100);
        do_load(4'h5, 4'hA, 4'h0, 1'b1);
        wait_k(127);
        do_load(4'h5, 4'hA, 4'h3, 1'b1);
        wait_k(131);
        chk("bnd_old_an", an, 4'b1110);
        chk("bnd_old_seg", seg, 7'h40);
        wait_k(163);
        chk("bnd_new_seg", seg, 7'h30);

        wait_k(169);
        do_load(4'h5, 4'hA, 4'h2, 1'b1);
        wait_k(172);
        do_load(4'h5, 4'hA, 4'h9, 1'b1);
        saw24 = 1'b0;
        saw10 = 1'b0;
        while (k < 240) begin
            @(negedge clock);
            if (an == 4'b1110 && seg == 7'h24) saw24 = 1'b1;
            if (an == 4'b1110 && seg == 7'h10) saw10 = 1'b1;
        end
        chk("never_0x24", saw24, 1'b0);
        chk("shows_0x10", saw10, 1'b1);

        nf = 0;
        lastf = 0;
        while (k < 310) begin
            @(negedge clock);
            if (frame) begin
                nf++;
                chk("frame_an", an, 4'hF);
                if (lastf != 0) chk("frame_gap", k - lastf, 32);
                lastf = k;
            end
        end
        chk("frame_count", nf, 2);

        wait_k(341);
        chk("pre_rst_an", an, 4'b1011);
        #2 reset = 1'b1;
        #1;
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_valid", valid, 1'b0);
        chk("rst_frame", frame, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        wait_k(3);
        chk("restart_an", an, 4'b1110);
        chk("restart_seg", seg, 7'h3F);
        chk("restart_valid", valid, 1'b0);
        wait_k(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
